// File: rtl/pico_ctrl_pkg.sv
// Shared types for the pico_mips control sequencer: opcodes, FSM states,
// the 6-bit control vector and the per-opcode final-cycle decode.
package pico_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_ADD    = 3'd1,
    OP_ALUI   = 3'd2,
    OP_BR     = 3'd3,
    OP_WAITSW = 3'd4,
    OP_HALT   = 3'd5
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    MULT_WAIT,
    FLUSH,
    WAIT_SW,
    HALT
  } state_e;

  typedef struct packed {
    logic bran;
    logic alu_flag;
    logic mult_flag;
    logic ram_flag;
    logic alu_ctrl;
    logic nw;
  } ctrl_s;

  localparam ctrl_s CTRL_NONE = '0;

  // Control vector presented on the retiring cycle of each opcode
  function automatic ctrl_s decode_op(input op_e op);
    ctrl_s c;
    c = CTRL_NONE;
    case (op)
      OP_MUL:  c = ctrl_s'(6'b001110);
      OP_ADD:  c = ctrl_s'(6'b000000);
      OP_ALUI: c = ctrl_s'(6'b010100);
      OP_BR:   c = ctrl_s'(6'b100001);
      default: c = CTRL_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pico_ctrl_decode.sv
// Combinational opcode decoder: maps a raw opcode to the op enum, its
// final-cycle control vector and a legal flag. Unknown opcodes decode as ADD.
module pico_ctrl_decode
  import pico_ctrl_pkg::*;
#(
  parameter int unsigned OP_W = 3
) (
  input  logic [OP_W-1:0] opcode,
  output op_e             op,
  output ctrl_s           ctrl,
  output logic            legal
);

  // Range-check the opcode, fold illegal values onto ADD, look up the vector
  always_comb begin
    legal = (opcode <= OP_W'(5));
    op    = legal ? op_e'(opcode[2:0]) : OP_ADD;
    ctrl  = decode_op(op);
  end

endmodule

// File: rtl/pico_ctrl_seq.sv
// Sequential control unit: accepts opcodes over valid/ready, sequences
// multi-cycle ops (MUL, BR flush, WAITSW, HALT) and issues registered strobes.
module pico_ctrl_seq
  import pico_ctrl_pkg::*;
#(
  parameter int unsigned OP_W      = 3,
  parameter int unsigned MULT_LAT  = 2,
  parameter int unsigned FLUSH_LAT = 1
) (
  input  logic            clk,
  input  logic            n_reset,
  input  logic [OP_W-1:0] opcode,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic            sw_ready,
  output logic            alu_flag,
  output logic            ram_flag,
  output logic            alu_ctrl,
  output logic            bran,
  output logic            nw,
  output logic            mult_flag,
  output logic            pc_en,
  output logic            illegal,
  output logic            halted
);

  localparam int unsigned MAX_LAT = (MULT_LAT > FLUSH_LAT) ? MULT_LAT : FLUSH_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_s            ctrl_q, ctrl_d;
  logic             pc_en_q, pc_en_d;
  logic             ready_q, ready_d;
  logic             illegal_q, illegal_d;
  logic             halted_q, halted_d;

  op_e              dec_op;
  ctrl_s            dec_ctrl;
  logic             dec_legal;

  pico_ctrl_decode #(
    .OP_W (OP_W)
  ) u_decode (
    .opcode (opcode),
    .op     (dec_op),
    .ctrl   (dec_ctrl),
    .legal  (dec_legal)
  );

  // Next-state logic; whenever ready_q is high the current op is retiring,
  // so a new opcode is launched from any state (no bubble between ops)
  always_comb begin
    state_d   = IDLE;
    cnt_d     = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
    ctrl_d    = CTRL_NONE;
    pc_en_d   = 1'b0;
    ready_d   = 1'b1;
    illegal_d = 1'b0;
    halted_d  = 1'b0;
    if (ready_q) begin
      if (instr_valid) begin
        case (dec_op)
          OP_MUL: begin
            if (MULT_LAT == 1) begin
              state_d = EXEC;
              ctrl_d  = dec_ctrl;
              pc_en_d = 1'b1;
            end else begin
              state_d          = MULT_WAIT;
              ctrl_d.mult_flag = 1'b1;
              cnt_d            = CNT_W'(MULT_LAT - 1);
              ready_d          = 1'b0;
            end
          end
          OP_BR: begin
            state_d = EXEC;
            ctrl_d  = dec_ctrl;
            pc_en_d = 1'b1;
            ready_d = (FLUSH_LAT == 0);
          end
          OP_WAITSW: begin
            if (sw_ready) begin
              state_d = EXEC;
              pc_en_d = 1'b1;
            end else begin
              state_d = WAIT_SW;
              ready_d = 1'b0;
            end
          end
          OP_HALT: begin
            state_d  = HALT;
            halted_d = 1'b1;
            ready_d  = 1'b0;
          end
          default: begin
            state_d   = EXEC;
            ctrl_d    = dec_ctrl;
            pc_en_d   = 1'b1;
            illegal_d = ~dec_legal;
          end
        endcase
      end
    end else begin
      case (state_q)
        EXEC: begin
          // only a branch with a non-zero flush leaves EXEC not ready
          state_d = FLUSH;
          cnt_d   = CNT_W'(FLUSH_LAT - 1);
          ready_d = 1'b0;
        end
        MULT_WAIT: begin
          state_d = MULT_WAIT;
          if (cnt_q == CNT_W'(1)) begin
            ctrl_d  = decode_op(OP_MUL);
            pc_en_d = 1'b1;
          end else begin
            ctrl_d.mult_flag = 1'b1;
            ready_d          = 1'b0;
          end
        end
        FLUSH: begin
          if (cnt_q != '0) begin
            state_d = FLUSH;
            ready_d = 1'b0;
          end
        end
        WAIT_SW: begin
          if (sw_ready) begin
            pc_en_d = 1'b1;
          end else begin
            state_d = WAIT_SW;
            ready_d = 1'b0;
          end
        end
        HALT: begin
          state_d  = HALT;
          halted_d = 1'b1;
          ready_d  = 1'b0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, counter and output registers with asynchronous reset
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ctrl_q    <= CTRL_NONE;
      pc_en_q   <= 1'b0;
      ready_q   <= 1'b1;
      illegal_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      pc_en_q   <= pc_en_d;
      ready_q   <= ready_d;
      illegal_q <= illegal_d;
      halted_q  <= halted_d;
    end
  end

  assign bran        = ctrl_q.bran;
  assign alu_flag    = ctrl_q.alu_flag;
  assign mult_flag   = ctrl_q.mult_flag;
  assign ram_flag    = ctrl_q.ram_flag;
  assign alu_ctrl    = ctrl_q.alu_ctrl;
  assign nw          = ctrl_q.nw;
  assign pc_en       = pc_en_q;
  assign instr_ready = ready_q;
  assign illegal     = illegal_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_pico_ctrl_seq.sv
// Directed bench for pico_ctrl_seq. Output vectors are packed as
// {bran, alu_flag, mult_flag, ram_flag, alu_ctrl, nw, pc_en, ready, illegal, halted}.
module tb_pico_ctrl_seq;

  localparam logic [9:0] RST  = 10'b000000_0_1_0_0;
  localparam logic [9:0] ZERO = 10'b000000_0_0_0_0;

  logic       clk = 1'b0;
  logic       n_reset = 1'b1;
  logic [2:0] opcode = 3'd0;
  logic       instr_valid = 1'b0;
  logic       sw_ready = 1'b0;

  logic a_rdy, a_alu, a_ram, a_actl, a_bran, a_nw, a_mult, a_pc, a_ill, a_halt;
  logic b_rdy, b_alu, b_ram, b_actl, b_bran, b_nw, b_mult, b_pc, b_ill, b_halt;
  logic [9:0] a_out, b_out;

  assign a_out = {a_bran, a_alu, a_mult, a_ram, a_actl, a_nw, a_pc, a_rdy, a_ill, a_halt};
  assign b_out = {b_bran, b_alu, b_mult, b_ram, b_actl, b_nw, b_pc, b_rdy, b_ill, b_halt};

  always #5 clk = ~clk;

  pico_ctrl_seq #(.OP_W(3), .MULT_LAT(1), .FLUSH_LAT(0)) dut_a (
    .clk(clk), .n_reset(n_reset), .opcode(opcode), .instr_valid(instr_valid),
    .instr_ready(a_rdy), .sw_ready(sw_ready), .alu_flag(a_alu), .ram_flag(a_ram),
    .alu_ctrl(a_actl), .bran(a_bran), .nw(a_nw), .mult_flag(a_mult),
    .pc_en(a_pc), .illegal(a_ill), .halted(a_halt)
  );

  pico_ctrl_seq #(.OP_W(3), .MULT_LAT(3), .FLUSH_LAT(2)) dut_b (
    .clk(clk), .n_reset(n_reset), .opcode(opcode), .instr_valid(instr_valid),
    .instr_ready(b_rdy), .sw_ready(sw_ready), .alu_flag(b_alu), .ram_flag(b_ram),
    .alu_ctrl(b_actl), .bran(b_bran), .nw(b_nw), .mult_flag(b_mult),
    .pc_en(b_pc), .illegal(b_ill), .halted(b_halt)
  );

  typedef struct {
    logic [2:0] op;
    logic       valid;
    logic       sw;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[15];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    instr_valid = 1'b0;
    sw_ready    = 1'b0;
    n_reset     = 1'b0;
    @(posedge clk);
    #1;
    n_reset = 1'b1;
  endtask

  initial begin
    int pc_cnt;
    int acc_a, acc_b, pc_a, pc_b, ill_exp_a, ill_a, ill_exp_b, ill_b;
    int op;

    // op, valid, sw, expected DUT A (MULT_LAT=1, FLUSH_LAT=0) outputs after the edge
    tbl[0]  = '{3'd0, 1'b1, 1'b0, 10'b001110_1_1_0_0}; // MUL
    tbl[1]  = '{3'd1, 1'b1, 1'b0, 10'b000000_1_1_0_0}; // ADD
    tbl[2]  = '{3'd2, 1'b1, 1'b0, 10'b010100_1_1_0_0}; // ALUI
    tbl[3]  = '{3'd3, 1'b1, 1'b0, 10'b100001_1_1_0_0}; // BR, no flush
    tbl[4]  = '{3'd7, 1'b1, 1'b0, 10'b000000_1_1_1_0}; // illegal
    tbl[5]  = '{3'd4, 1'b1, 1'b1, 10'b000000_1_1_0_0}; // WAITSW, switch already set
    tbl[6]  = '{3'd1, 1'b0, 1'b0, 10'b000000_0_1_0_0}; // idle
    tbl[7]  = '{3'd4, 1'b1, 1'b0, 10'b000000_0_0_0_0}; // WAITSW waiting
    tbl[8]  = '{3'd1, 1'b1, 1'b0, 10'b000000_0_0_0_0}; // ADD held, not taken
    tbl[9]  = '{3'd1, 1'b1, 1'b1, 10'b000000_1_1_0_0}; // WAITSW retires
    tbl[10] = '{3'd1, 1'b1, 1'b0, 10'b000000_1_1_0_0}; // held ADD taken
    tbl[11] = '{3'd1, 1'b0, 1'b0, 10'b000000_0_1_0_0}; // idle
    tbl[12] = '{3'd5, 1'b1, 1'b0, 10'b000000_0_0_0_1}; // HALT
    tbl[13] = '{3'd1, 1'b1, 1'b0, 10'b000000_0_0_0_1}; // stays halted
    tbl[14] = '{3'd0, 1'b1, 1'b1, 10'b000000_0_0_0_1}; // stays halted

    // reset values, before any clock edge
    #1 n_reset = 1'b0;
    #1;
    chk("reset_a", a_out, RST);
    chk("reset_b", b_out, RST);
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    step();
    chk("post_reset_idle_a", a_out, RST);
    chk("post_reset_idle_b", b_out, RST);

    // table-driven vectors on DUT A
    pc_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      opcode      = tbl[i].op;
      instr_valid = tbl[i].valid;
      sw_ready    = tbl[i].sw;
      step();
      if (i < 4 && a_pc) pc_cnt++;
      chk($sformatf("vec%0d", i), a_out, tbl[i].exp);
    end
    chk_int("legacy_pc_pulses", pc_cnt, 4);

    // MUL with MULT_LAT=3 on DUT B
    do_reset();
    opcode = 3'd0; instr_valid = 1'b1;
    step();
    chk("mul3_c1", b_out, 10'b001000_0_0_0_0);
    instr_valid = 1'b0;
    step();
    chk("mul3_c2", b_out, 10'b001000_0_0_0_0);
    step();
    chk("mul3_c3", b_out, 10'b001110_1_1_0_0);
    step();
    chk("mul3_done", b_out, RST);

    // BR with FLUSH_LAT=2 followed by a held ADD on DUT B
    do_reset();
    pc_cnt = 0;
    opcode = 3'd3; instr_valid = 1'b1;
    step();
    if (b_pc) pc_cnt++;
    chk("br_strobe", b_out, 10'b100001_1_0_0_0);
    opcode = 3'd1;
    step();
    if (b_pc) pc_cnt++;
    chk("br_flush1", b_out, ZERO);
    step();
    if (b_pc) pc_cnt++;
    chk("br_flush2", b_out, ZERO);
    step();
    if (b_pc) pc_cnt++;
    chk("br_ready_back", b_out, RST);
    step();
    if (b_pc) pc_cnt++;
    chk("br_add_taken", b_out, 10'b000000_1_1_0_0);
    instr_valid = 1'b0;
    chk_int("br_add_pc_pulses", pc_cnt, 2);

    // WAITSW with switch low for 5 samples, then HALT held valid on DUT B
    do_reset();
    opcode = 3'd4; instr_valid = 1'b1; sw_ready = 1'b0;
    step();
    chk("waitsw_c1", b_out, ZERO);
    instr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("waitsw_hold%0d", i), b_out, ZERO);
    end
    sw_ready = 1'b1;
    step();
    chk("waitsw_retire", b_out, 10'b000000_1_1_0_0);
    sw_ready = 1'b0; opcode = 3'd5; instr_valid = 1'b1;
    step();
    chk("halt_enter", b_out, 10'b000000_0_0_0_1);
    opcode = 3'd1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("halt_stay%0d", i), b_out, 10'b000000_0_0_0_1);
    end

    // asynchronous reset mid-MULT_WAIT on DUT B
    do_reset();
    opcode = 3'd0; instr_valid = 1'b1;
    step();
    chk("async_pre", b_out, 10'b001000_0_0_0_0);
    instr_valid = 1'b0;
    #2 n_reset = 1'b0;
    #1;
    chk("async_rst_b", b_out, RST);
    @(posedge clk);
    #1;
    n_reset = 1'b1;

    // random opcode stream on both configurations
    do_reset();
    acc_a = 0; acc_b = 0; pc_a = 0; pc_b = 0;
    ill_exp_a = 0; ill_a = 0; ill_exp_b = 0; ill_b = 0;
    for (int i = 0; i < 1000; i++) begin
      op = int'($urandom_range(0, 7));
      if (op == 5) op = 1;
      opcode      = 3'(op);
      instr_valid = 1'($urandom_range(0, 1));
      sw_ready    = 1'($urandom_range(0, 1));
      if (instr_valid && a_rdy) begin
        acc_a++;
        if (op > 5) ill_exp_a++;
      end
      if (instr_valid && b_rdy) begin
        acc_b++;
        if (op > 5) ill_exp_b++;
      end
      step();
      if (a_pc) pc_a++;
      if (b_pc) pc_b++;
      if (a_ill) ill_a++;
      if (b_ill) ill_b++;
    end
    instr_valid = 1'b0;
    sw_ready    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (a_pc) pc_a++;
      if (b_pc) pc_b++;
    end
    chk_int("rand_pc_a", pc_a, acc_a);
    chk_int("rand_pc_b", pc_b, acc_b);
    chk_int("rand_ill_a", ill_a, ill_exp_a);
    chk_int("rand_ill_b", ill_b, ill_exp_b);
    chk("rand_idle_a", a_out, RST);
    chk("rand_idle_b", b_out, RST);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
